// File: rtl/wb_read_fifo_pkg.sv
// wb_read_fifo_pkg
// Shared types for the pull-style Wishbone read FIFO: the two FSM state
// encodings and the byte type stored in the buffer.
package wb_read_fifo_pkg;

    typedef enum logic {
        F_IDLE,
        F_FETCH
    } fetch_state_t;

    typedef enum logic {
        S_IDLE,
        S_ACK
    } serve_state_t;

    typedef logic [7:0] byte_t;

endpackage

// File: rtl/wb_read_fifo_ptr.sv
// wb_read_fifo_ptr
// Wrapping buffer pointer. Advances by one on every clock where inc_i is
// high and wraps naturally modulo 2**ADDR_WIDTH.
// Ports:
//   clk_i   system clock, rising edge
//   rst_ni  asynchronous active-low reset, pointer returns to 0
//   inc_i   advance the pointer this cycle
//   ptr_o   current pointer value
module wb_read_fifo_ptr #(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  inc_i,
    output logic [ADDR_WIDTH-1:0] ptr_o
);

    logic [ADDR_WIDTH-1:0] ptr_q;
    logic [ADDR_WIDTH-1:0] ptr_d;

    // Next pointer value; the natural overflow of the adder gives the wrap.
    always_comb begin
        ptr_d = ptr_q;
        if (inc_i) begin
            ptr_d = ptr_q + ADDR_WIDTH'(1);
        end
    end

    // Pointer register, cleared as soon as reset is asserted.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/wb_read_fifo.sv
// wb_read_fifo
// Pull-style byte FIFO. The upstream Wishbone classic controller fetches
// bytes from a source device whenever there is free space; the downstream
// Wishbone classic device answers consumer read cycles by popping the head.
// Optional feature macro: WB_READ_FIFO_EMPTY_ERR_EN -- when defined, a read
// on an empty FIFO is answered with a one-cycle s_err_o instead of waiting.
// Ports:
//   clk_i    system clock          rst_ni   async active-low reset
//   m_cyc_o  upstream cycle        m_stb_o  upstream strobe
//   m_we_o   upstream write (0)    m_dat_i  upstream read data
//   m_ack_i  upstream acknowledge
//   s_cyc_i  downstream cycle      s_stb_i  downstream strobe
//   s_we_i   downstream write      s_dat_o  downstream read data
//   s_ack_o  downstream ack        s_err_o  downstream error
//   level_o  occupancy 0..DEPTH
module wb_read_fifo
    import wb_read_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    output logic                m_cyc_o,
    output logic                m_stb_o,
    output logic                m_we_o,
    input  logic [7:0]          m_dat_i,
    input  logic                m_ack_i,
    input  logic                s_cyc_i,
    input  logic                s_stb_i,
    input  logic                s_we_i,
    output logic [7:0]          s_dat_o,
    output logic                s_ack_o,
    output logic                s_err_o,
    output logic [ADDR_WIDTH:0] level_o
);

    localparam int                DEPTH      = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

    fetch_state_t          fetchState_q;
    fetch_state_t          fetchState_d;
    serve_state_t          serveState_q;
    serve_state_t          serveState_d;
    logic [ADDR_WIDTH:0]   count_q;
    logic [ADDR_WIDTH:0]   count_d;
    byte_t                 mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] rdPtr;
    logic [ADDR_WIDTH-1:0] wrPtr;
    logic                  sAck_q;
    logic                  sAck_d;
    logic                  sErr_q;
    logic                  sErr_d;
    byte_t                 sDat_q;
    byte_t                 sDat_d;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic                  request;

    assign full  = (count_q == FULL_COUNT);
    assign empty = (count_q == '0);

    // An ack only lands data while we are actually strobing; stray acks
    // in F_IDLE are ignored. The full guard is redundant with the FSM but
    // keeps the no-push-when-full rule local to this line.
    assign push = (fetchState_q == F_FETCH) && m_ack_i && !full;

    // A new consumer request is only recognised while no response pulse is
    // on the bus, so a held request is served once per ack/err pulse.
    assign request = s_cyc_i && s_stb_i && !sAck_q && !sErr_q;
    assign pop     = (serveState_q == S_IDLE) && request && !s_we_i && !empty;

    wb_read_fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_rd_ptr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (pop),
        .ptr_o  (rdPtr)
    );

    wb_read_fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr_ptr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (push),
        .ptr_o  (wrPtr)
    );

    // Occupancy: a simultaneous push and pop leaves the count unchanged.
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + (ADDR_WIDTH + 1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (ADDR_WIDTH + 1)'(1);
        end
    end

    // Count register and byte storage; reset clears every entry so the
    // buffer never holds stale data from before reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            if (push) begin
                mem_q[wrPtr] <= m_dat_i;
            end
        end
    end

    // Fetch FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fetchState_q <= F_IDLE;
        end else begin
            fetchState_q <= fetchState_d;
        end
    end

    // Fetch FSM next state. The strobe is kept up back-to-back after a push
    // unless that push fills the buffer, judged on the post-edge count so a
    // same-cycle pop keeps the fetch going.
    always_comb begin
        fetchState_d = fetchState_q;
        case (fetchState_q)
            F_IDLE: begin
                if (!full) begin
                    fetchState_d = F_FETCH;
                end
            end
            F_FETCH: begin
                if (push && (count_d == FULL_COUNT)) begin
                    fetchState_d = F_IDLE;
                end
            end
            default: fetchState_d = F_IDLE;
        endcase
    end

    // Fetch FSM outputs decode straight from the state register, so they
    // change only on a clock edge or reset.
    always_comb begin
        m_cyc_o = (fetchState_q == F_FETCH);
        m_stb_o = (fetchState_q == F_FETCH);
        m_we_o  = 1'b0;
    end

    // Serve FSM state register together with the registered bus responses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            serveState_q <= S_IDLE;
            sAck_q       <= 1'b0;
            sErr_q       <= 1'b0;
            sDat_q       <= '0;
        end else begin
            serveState_q <= serveState_d;
            sAck_q       <= sAck_d;
            sErr_q       <= sErr_d;
            sDat_q       <= sDat_d;
        end
    end

    // Serve FSM next state: any accepted request moves to the one-cycle
    // response state, which always returns to idle.
    always_comb begin
        serveState_d = serveState_q;
        case (serveState_q)
            S_IDLE: begin
                if (request) begin
`ifdef WB_READ_FIFO_EMPTY_ERR_EN
                    serveState_d = S_ACK;
`else
                    if (s_we_i || !empty) begin
                        serveState_d = S_ACK;
                    end
`endif
                end
            end
            S_ACK:   serveState_d = S_IDLE;
            default: serveState_d = S_IDLE;
        endcase
    end

    // Serve FSM response values. Read data is captured with the ack and the
    // pop happens on that same edge. Without the empty-error feature an
    // empty read simply produces nothing, which holds the consumer in wait
    // states until a byte arrives.
    always_comb begin
        sAck_d = 1'b0;
        sErr_d = 1'b0;
        sDat_d = sDat_q;
        if ((serveState_q == S_IDLE) && request) begin
            if (s_we_i) begin
                sErr_d = 1'b1;
            end else if (!empty) begin
                sAck_d = 1'b1;
                sDat_d = mem_q[rdPtr];
            end else begin
`ifdef WB_READ_FIFO_EMPTY_ERR_EN
                sErr_d = 1'b1;
`else
                sErr_d = 1'b0;
`endif
            end
        end
    end

    assign s_ack_o = sAck_q;
    assign s_err_o = sErr_q;
    assign s_dat_o = sDat_q;
    assign level_o = count_q;

endmodule

// File: tb/tb_wb_read_fifo.sv
// tb_wb_read_fifo
// Self-checking bench for wb_read_fifo. A queue of expected bytes is filled
// whenever the bench's source model acknowledges a strobe and emptied as
// the consumer side returns data; its size is also the expected level.
module tb_wb_read_fifo;
    import wb_read_fifo_pkg::*;

    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        m_cyc_o;
    logic        m_stb_o;
    logic        m_we_o;
    logic [7:0]  m_dat_i = '0;
    logic        m_ack_i = 1'b0;
    logic        s_cyc_i = 1'b0;
    logic        s_stb_i = 1'b0;
    logic        s_we_i = 1'b0;
    logic [7:0]  s_dat_o;
    logic        s_ack_o;
    logic        s_err_o;
    logic [AW:0] level_o;

    byte_t expQ[$];
    int    total = 0;
    int    bad = 0;

    wb_read_fifo #(.ADDR_WIDTH(AW)) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .m_cyc_o (m_cyc_o),
        .m_stb_o (m_stb_o),
        .m_we_o  (m_we_o),
        .m_dat_i (m_dat_i),
        .m_ack_i (m_ack_i),
        .s_cyc_i (s_cyc_i),
        .s_stb_i (s_stb_i),
        .s_we_i  (s_we_i),
        .s_dat_o (s_dat_o),
        .s_ack_o (s_ack_o),
        .s_err_o (s_err_o),
        .level_o (level_o)
    );

    always #5 clk_i = ~clk_i;

    // Source model: acknowledge each strobe with base, base+1, ... until n
    // bytes have been delivered; returns at a negedge with ack dropped.
    task automatic fetch_bytes(input int n, input byte_t base, output bit timedOut);
        int got;
        int cyc;
        got = 0;
        cyc = 0;
        while (got < n && cyc < 200) begin
            @(negedge clk_i);
            if (m_stb_o) begin
                m_ack_i = 1'b1;
                m_dat_i = base + byte_t'(got);
                expQ.push_back(m_dat_i);
                got++;
            end else begin
                m_ack_i = 1'b0;
            end
            cyc++;
        end
        @(negedge clk_i);
        m_ack_i = 1'b0;
        m_dat_i = '0;
        timedOut = (got < n);
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (2) @(negedge clk_i);
        total++; if (m_cyc_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_cyc: got %b want 0", m_cyc_o); end
        total++; if (m_stb_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_stb: got %b want 0", m_stb_o); end
        total++; if (m_we_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_we: got %b want 0", m_we_o); end
        total++; if (s_ack_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_ack: got %b want 0", s_ack_o); end
        total++; if (s_err_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_err: got %b want 0", s_err_o); end
        total++; if (s_dat_o !== 8'h00) begin bad++; $display("[TB] FAIL reset_dat: got %h want 00", s_dat_o); end
        total++; if (level_o !== 0) begin bad++; $display("[TB] FAIL reset_level: got %0d want 0", level_o); end
        rst_ni = 1'b1;
        @(negedge clk_i);
        total++; if (m_cyc_o !== 1'b1) begin bad++; $display("[TB] FAIL release_cyc: got %b want 1", m_cyc_o); end
    endtask

    task automatic test_fill();
        int n;
        int cyc;
        n = 0;
        cyc = 0;
        while (n < DEPTH && cyc < 100) begin
            @(negedge clk_i);
            total++; if (level_o !== n) begin bad++; $display("[TB] FAIL fill_level: got %0d want %0d", level_o, n); end
            if (m_stb_o) begin
                m_ack_i = 1'b1;
                m_dat_i = 8'h10 + byte_t'(n);
                expQ.push_back(m_dat_i);
                n++;
            end else begin
                m_ack_i = 1'b0;
            end
            cyc++;
        end
        @(negedge clk_i);
        m_ack_i = 1'b0;
        total++; if (n != DEPTH) begin bad++; $display("[TB] FAIL fill_timeout: got %0d want %0d", n, DEPTH); end
        total++; if (level_o !== DEPTH) begin bad++; $display("[TB] FAIL full_level: got %0d want %0d", level_o, DEPTH); end
        total++; if (m_cyc_o !== 1'b0) begin bad++; $display("[TB] FAIL full_cyc: got %b want 0", m_cyc_o); end
        m_ack_i = 1'b1;
        m_dat_i = 8'hEE;
        @(negedge clk_i);
        m_ack_i = 1'b0;
        m_dat_i = '0;
        total++; if (level_o !== DEPTH) begin bad++; $display("[TB] FAIL idle_ack_level: got %0d want %0d", level_o, DEPTH); end
        total++; if (m_stb_o !== 1'b0) begin bad++; $display("[TB] FAIL idle_ack_stb: got %b want 0", m_stb_o); end
    endtask

    task automatic test_full_read();
        byte_t want;
        s_cyc_i = 1'b1;
        s_stb_i = 1'b1;
        s_we_i  = 1'b0;
        @(negedge clk_i);
        s_cyc_i = 1'b0;
        s_stb_i = 1'b0;
        want = expQ.pop_front();
        total++; if (s_ack_o !== 1'b1) begin bad++; $display("[TB] FAIL full_read_ack: got %b want 1", s_ack_o); end
        total++; if (s_dat_o !== 8'h10) begin bad++; $display("[TB] FAIL full_read_dat: got %h want 10", s_dat_o); end
        total++; if (want !== 8'h10) begin bad++; $display("[TB] FAIL full_read_head: got %h want 10", want); end
        total++; if (level_o !== DEPTH - 1) begin bad++; $display("[TB] FAIL full_read_level: got %0d want %0d", level_o, DEPTH - 1); end
        total++; if (m_stb_o !== 1'b0) begin bad++; $display("[TB] FAIL full_read_stb_early: got %b want 0", m_stb_o); end
        @(negedge clk_i);
        total++; if (m_stb_o !== 1'b1) begin bad++; $display("[TB] FAIL refetch_stb: got %b want 1", m_stb_o); end
        total++; if (s_ack_o !== 1'b0) begin bad++; $display("[TB] FAIL ack_pulse_len: got %b want 0", s_ack_o); end
    endtask

    task automatic test_simultaneous();
        byte_t want;
        int guard;
        guard = 0;
        while (expQ.size() > 7 && guard < 20) begin
            s_cyc_i = 1'b1;
            s_stb_i = 1'b1;
            @(negedge clk_i);
            s_cyc_i = 1'b0;
            s_stb_i = 1'b0;
            want = expQ.pop_front();
            total++; if (s_ack_o !== 1'b1 || s_dat_o !== want) begin bad++; $display("[TB] FAIL drain7_read: got ack=%b dat=%h want ack=1 dat=%h", s_ack_o, s_dat_o, want); end
            total++; if (level_o !== expQ.size()) begin bad++; $display("[TB] FAIL drain7_level: got %0d want %0d", level_o, expQ.size()); end
            @(negedge clk_i);
            guard++;
        end
        total++; if (m_stb_o !== 1'b1) begin bad++; $display("[TB] FAIL simul_stb: got %b want 1", m_stb_o); end
        want = expQ.pop_front();
        m_ack_i = 1'b1;
        m_dat_i = 8'hC7;
        expQ.push_back(8'hC7);
        s_cyc_i = 1'b1;
        s_stb_i = 1'b1;
        @(negedge clk_i);
        m_ack_i = 1'b0;
        s_cyc_i = 1'b0;
        s_stb_i = 1'b0;
        total++; if (s_ack_o !== 1'b1 || s_dat_o !== want) begin bad++; $display("[TB] FAIL simul_read: got ack=%b dat=%h want ack=1 dat=%h", s_ack_o, s_dat_o, want); end
        total++; if (level_o !== 7) begin bad++; $display("[TB] FAIL simul_level: got %0d want 7", level_o); end
        @(negedge clk_i);
    endtask

    task automatic test_drain();
        byte_t want;
        int guard;
        guard = 0;
        while (expQ.size() > 0 && guard < 20) begin
            s_cyc_i = 1'b1;
            s_stb_i = 1'b1;
            @(negedge clk_i);
            s_cyc_i = 1'b0;
            s_stb_i = 1'b0;
            want = expQ.pop_front();
            total++; if (s_ack_o !== 1'b1 || s_dat_o !== want) begin bad++; $display("[TB] FAIL drain_read: got ack=%b dat=%h want ack=1 dat=%h", s_ack_o, s_dat_o, want); end
            @(negedge clk_i);
            guard++;
        end
        total++; if (s_dat_o !== 8'hC7) begin bad++; $display("[TB] FAIL drain_tail: got %h want c7", s_dat_o); end
        total++; if (level_o !== 0) begin bad++; $display("[TB] FAIL drain_level: got %0d want 0", level_o); end
    endtask

`ifdef WB_READ_FIFO_EMPTY_ERR_EN
    task automatic test_empty_err();
        s_cyc_i = 1'b1;
        s_stb_i = 1'b1;
        @(negedge clk_i);
        s_cyc_i = 1'b0;
        s_stb_i = 1'b0;
        total++; if (s_err_o !== 1'b1 || s_ack_o !== 1'b0) begin bad++; $display("[TB] FAIL empty_err: got err=%b ack=%b want err=1 ack=0", s_err_o, s_ack_o); end
        total++; if (level_o !== 0) begin bad++; $display("[TB] FAIL empty_err_level: got %0d want 0", level_o); end
        @(negedge clk_i);
        total++; if (s_err_o !== 1'b0) begin bad++; $display("[TB] FAIL empty_err_len: got %b want 0", s_err_o); end
    endtask
`else
    task automatic test_empty_wait();
        byte_t want;
        s_cyc_i = 1'b1;
        s_stb_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            total++; if (s_ack_o !== 1'b0 || s_err_o !== 1'b0) begin bad++; $display("[TB] FAIL empty_wait: got ack=%b err=%b want 0 0", s_ack_o, s_err_o); end
        end
        m_ack_i = 1'b1;
        m_dat_i = 8'hA5;
        expQ.push_back(8'hA5);
        @(negedge clk_i);
        m_ack_i = 1'b0;
        total++; if (s_ack_o !== 1'b0) begin bad++; $display("[TB] FAIL no_bypass: got %b want 0", s_ack_o); end
        total++; if (level_o !== 1) begin bad++; $display("[TB] FAIL wait_push_level: got %0d want 1", level_o); end
        @(negedge clk_i);
        s_cyc_i = 1'b0;
        s_stb_i = 1'b0;
        want = expQ.pop_front();
        total++; if (s_ack_o !== 1'b1 || s_dat_o !== 8'hA5 || want !== 8'hA5) begin bad++; $display("[TB] FAIL wait_read: got ack=%b dat=%h want ack=1 dat=a5", s_ack_o, s_dat_o); end
        total++; if (level_o !== 0) begin bad++; $display("[TB] FAIL wait_level: got %0d want 0", level_o); end
        @(negedge clk_i);
    endtask

    task automatic test_abandon();
        s_cyc_i = 1'b1;
        s_stb_i = 1'b1;
        repeat (2) @(negedge clk_i);
        s_cyc_i = 1'b0;
        m_ack_i = 1'b1;
        m_dat_i = 8'h3B;
        expQ.push_back(8'h3B);
        @(negedge clk_i);
        m_ack_i = 1'b0;
        @(negedge clk_i);
        s_stb_i = 1'b0;
        total++; if (s_ack_o !== 1'b0) begin bad++; $display("[TB] FAIL abandon_ack: got %b want 0", s_ack_o); end
        total++; if (level_o !== 1) begin bad++; $display("[TB] FAIL abandon_level: got %0d want 1", level_o); end
    endtask
`endif

    task automatic test_write_err();
        bit to;
        byte_t want;
        int lvl;
        fetch_bytes(1, 8'h3C, to);
        total++; if (to) begin bad++; $display("[TB] FAIL werr_fetch_timeout: got timeout want none"); end
        lvl = expQ.size();
        s_cyc_i = 1'b1;
        s_stb_i = 1'b1;
        s_we_i  = 1'b1;
        @(negedge clk_i);
        s_cyc_i = 1'b0;
        s_stb_i = 1'b0;
        s_we_i  = 1'b0;
        total++; if (s_err_o !== 1'b1 || s_ack_o !== 1'b0) begin bad++; $display("[TB] FAIL werr_pulse: got err=%b ack=%b want err=1 ack=0", s_err_o, s_ack_o); end
        total++; if (level_o !== lvl) begin bad++; $display("[TB] FAIL werr_level: got %0d want %0d", level_o, lvl); end
        @(negedge clk_i);
        total++; if (s_err_o !== 1'b0) begin bad++; $display("[TB] FAIL werr_len: got %b want 0", s_err_o); end
        while (expQ.size() > 0) begin
            s_cyc_i = 1'b1;
            s_stb_i = 1'b1;
            @(negedge clk_i);
            s_cyc_i = 1'b0;
            s_stb_i = 1'b0;
            want = expQ.pop_front();
            total++; if (s_ack_o !== 1'b1 || s_dat_o !== want) begin bad++; $display("[TB] FAIL werr_read: got ack=%b dat=%h want ack=1 dat=%h", s_ack_o, s_dat_o, want); end
            @(negedge clk_i);
        end
    endtask

    task automatic test_reset_mid();
        bit to;
        byte_t want;
        fetch_bytes(10, 8'h60, to);
        total++; if (to) begin bad++; $display("[TB] FAIL rmid_fetch_timeout: got timeout want none"); end
        s_cyc_i = 1'b1;
        s_stb_i = 1'b1;
        @(negedge clk_i);
        s_cyc_i = 1'b0;
        s_stb_i = 1'b0;
        want = expQ.pop_front();
        total++; if (s_ack_o !== 1'b1 || m_cyc_o !== 1'b1 || level_o !== 9) begin bad++; $display("[TB] FAIL rmid_pre: got ack=%b cyc=%b level=%0d want 1 1 9", s_ack_o, m_cyc_o, level_o); end
        #2 rst_ni = 1'b0;
        #1;
        total++; if (m_cyc_o !== 1'b0 || m_stb_o !== 1'b0) begin bad++; $display("[TB] FAIL rmid_cyc: got cyc=%b stb=%b want 0 0", m_cyc_o, m_stb_o); end
        total++; if (s_ack_o !== 1'b0) begin bad++; $display("[TB] FAIL rmid_ack: got %b want 0", s_ack_o); end
        total++; if (level_o !== 0) begin bad++; $display("[TB] FAIL rmid_level: got %0d want 0", level_o); end
        expQ.delete();
        @(negedge clk_i);
        rst_ni = 1'b1;
        fetch_bytes(1, 8'h77, to);
        total++; if (to) begin bad++; $display("[TB] FAIL rmid_refetch_timeout: got timeout want none"); end
        s_cyc_i = 1'b1;
        s_stb_i = 1'b1;
        @(negedge clk_i);
        s_cyc_i = 1'b0;
        s_stb_i = 1'b0;
        want = expQ.pop_front();
        total++; if (s_ack_o !== 1'b1 || s_dat_o !== want || want !== 8'h77) begin bad++; $display("[TB] FAIL rmid_first: got ack=%b dat=%h want ack=1 dat=77", s_ack_o, s_dat_o); end
        total++; if (level_o !== 0) begin bad++; $display("[TB] FAIL rmid_final_level: got %0d want 0", level_o); end
    endtask

    initial begin
        $display("[TB] starting wb_read_fifo bench");
        test_reset();
        test_fill();
        test_full_read();
        test_simultaneous();
        test_drain();
`ifdef WB_READ_FIFO_EMPTY_ERR_EN
        test_empty_err();
`else
        test_empty_wait();
        test_abandon();
`endif
        test_write_err();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
